// File: rtl/spi_slave_rx.sv
// SPI slave: resynchronizes the SPI bus into clk, assembles MOSI bytes into a
// first-word-fall-through RX FIFO and shifts a single reply byte out on MISO.
module spi_slave_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          spi_sclk,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_wr,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overflow,
    output logic                          underrun,
    output logic                          frame_active
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    // Synchronizer chains: bit 0 is the first stage, edges come from bits 1 and 2.
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] cs_sync_q, cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;

    logic cpol_q, cpol_d;
    logic cpha_q, cpha_d;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    // Only seven bits are kept: the eighth goes straight from MOSI into the FIFO.
    logic [6:0] rx_shift_q, rx_shift_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_pending_q, tx_pending_d;
    logic       underrun_q, underrun_d;

    logic       active;
    logic       cs_fall;
    logic       sclk_rise, sclk_fall;
    logic       lead_edge, trail_edge;
    logic       sample_edge, shift_edge;
    logic       push;
    logic [7:0] push_byte;
    logic       pop;
    logic       full;
    logic       wr_en;
    logic       tx_load;

    // NOTE: every always_comb assigns all of its outputs a default first, so no
    // path through the block can leave a value held and infer a latch.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};

        active    = ~cs_sync_q[1];
        cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
        sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
        sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

        // Mode only follows the pins between frames so it cannot change mid-byte.
        cpol_d = cs_sync_q[1] ? cpol : cpol_q;
        cpha_d = cs_sync_q[1] ? cpha : cpha_q;

        lead_edge   = cpol_q ? sclk_fall : sclk_rise;
        trail_edge  = cpol_q ? sclk_rise : sclk_fall;
        sample_edge = active & (cpha_q ? trail_edge : lead_edge);
        shift_edge  = active & (cpha_q ? lead_edge : trail_edge);
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        push       = 1'b0;
        push_byte  = {rx_shift_q, mosi_sync_q[1]};

        if (!active) begin
            bit_cnt_d  = 3'd0;
            rx_shift_d = 7'd0;
        end else if (sample_edge) begin
            rx_shift_d = push_byte[6:0];
            bit_cnt_d  = bit_cnt_q + 3'd1;
            push       = (bit_cnt_q == 3'd7);
        end
    end

    always_comb begin
        pop        = (count_q != '0) & rx_ready;
        full       = (count_q == FULL_COUNT);
        wr_en      = push & (~full | pop);
        overflow_d = push & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = push_byte;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_en && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // The trailing edge right after a cpha=0 end-of-byte load sees bit_cnt=0
    // and must not shift, otherwise the next byte would lose its MSB.
    always_comb begin
        tx_load = (!cpha_q && (cs_fall || (sample_edge && bit_cnt_q == 3'd7)))
                | (cpha_q && shift_edge && bit_cnt_q == 3'd0);

        tx_shift_d   = tx_shift_q;
        tx_hold_d    = tx_hold_q;
        tx_pending_d = tx_pending_q;
        underrun_d   = 1'b0;

        if (tx_load) begin
            tx_shift_d   = tx_pending_q ? tx_hold_q : 8'hFF;
            underrun_d   = ~tx_pending_q;
            tx_pending_d = 1'b0;
        end else if (shift_edge && bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        // A write in the same cycle as a load stays pending for the next load.
        if (tx_wr) begin
            tx_hold_d    = tx_data;
            tx_pending_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the values computed before this edge regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 3'b111;
            mosi_sync_q  <= 2'b00;
            cpol_q       <= 1'b0;
            cpha_q       <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            tx_shift_q   <= 8'd0;
            tx_hold_q    <= 8'd0;
            tx_pending_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            cpol_q       <= cpol_d;
            cpha_q       <= cpha_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            tx_shift_q   <= tx_shift_d;
            tx_hold_q    <= tx_hold_d;
            tx_pending_q <= tx_pending_d;
            underrun_q   <= underrun_d;
        end
    end

    // NOTE: the FIFO storage is reset on purpose: rx_data shows the head entry
    // directly and must read 0 during and right after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign frame_active = active;
    assign spi_miso     = active & tx_shift_q[7];
    assign rx_valid     = (count_q != '0);
    assign rx_data      = mem_q[rd_ptr_q];
    assign rx_count     = count_q;
    assign overflow     = overflow_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Self-checking bench for spi_slave_rx: a bit-level SPI master drives the bus,
// and a byte queue models the FIFO and the expected reply stream.
module tb_spi_slave_rx;

    localparam int DEPTH = 4;
    localparam int HALF  = 8;

    logic                     clk;
    logic                     rst_n;
    logic                     cpol, cpha;
    logic                     spi_sclk, spi_cs_n, spi_mosi;
    logic                     spi_miso;
    logic [7:0]               rx_data;
    logic                     rx_valid;
    logic                     rx_ready;
    logic [7:0]               tx_data;
    logic                     tx_wr;
    logic [$clog2(DEPTH):0]   rx_count;
    logic                     overflow, underrun, frame_active;

    int n_cmp;
    int n_bad;
    int ovf_pulses;
    int und_pulses;
    int push_lat;
    logic [7:0] model_q[$];
    logic [7:0] got_q[$];

    spi_slave_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .tx_data(tx_data), .tx_wr(tx_wr),
        .rx_count(rx_count), .overflow(overflow), .underrun(underrun),
        .frame_active(frame_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        ovf_pulses = 0;
        und_pulses = 0;
    end
    always @(negedge clk) begin
        if (overflow === 1'b1) ovf_pulses = ovf_pulses + 1;
        if (underrun === 1'b1) und_pulses = und_pulses + 1;
    end

    task automatic set_mode(input logic p, input logic h);
        cpol     = p;
        cpha     = h;
        spi_sclk = p;
        repeat (4) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        tx_data = b;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
    endtask

    task automatic frame_begin();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Half bit period after a sample edge; optionally records push latency and
    // raises rx_ready for exactly the cycle in which the push is committed.
    task automatic half_watch(input bit watch, input bit pop_at_push);
        logic [$clog2(DEPTH):0] c0;
        c0 = rx_count;
        for (int k = 1; k <= HALF; k++) begin
            @(negedge clk);
            if (watch) begin
                if (push_lat < 0 && rx_count !== c0) push_lat = k;
                if (pop_at_push && k == 2) rx_ready = 1'b1;
                if (pop_at_push && k == 3) rx_ready = 1'b0;
            end
        end
    endtask

    task automatic spi_byte(input logic [7:0] mo, input int nbits, input bit pop_at_push,
                            output logic [7:0] mi);
        mi       = 8'h00;
        push_lat = -1;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                spi_mosi = mo[i];
                repeat (HALF) @(negedge clk);
                mi[i]    = spi_miso;
                spi_sclk = ~spi_sclk;
                half_watch(i == 0, pop_at_push);
                spi_sclk = ~spi_sclk;
            end else begin
                spi_sclk = ~spi_sclk;
                spi_mosi = mo[i];
                repeat (HALF) @(negedge clk);
                mi[i]    = spi_miso;
                spi_sclk = ~spi_sclk;
                half_watch(i == 0, pop_at_push);
            end
        end
    endtask

    task automatic drain_fifo();
        got_q.delete();
        for (int g = 0; g < 4 * DEPTH && rx_valid === 1'b1; g++) begin
            got_q.push_back(rx_data);
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({spi_miso, rx_valid, overflow, underrun, frame_active} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {spi_miso, rx_valid, overflow, underrun, frame_active});
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data);
        end
        n_cmp++;
        if (int'(rx_count) !== 0) begin
            n_bad++; $display("FAIL reset_rx_count: got %0d want 0", rx_count);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({frame_active, rx_valid, spi_miso} !== 3'b0) begin
            n_bad++; $display("FAIL idle_after_reset: got %b want 000", {frame_active, rx_valid, spi_miso});
        end
    endtask

    task automatic test_mode0();
        logic [7:0] mi;
        set_mode(1'b0, 1'b0);
        write_tx(8'h3C);
        frame_begin();
        n_cmp++;
        if (frame_active !== 1'b1) begin
            n_bad++; $display("FAIL mode0_frame_active: got %b want 1", frame_active);
        end
        spi_byte(8'hA5, 8, 1'b0, mi);
        n_cmp++;
        if (push_lat !== 3) begin
            n_bad++; $display("FAIL mode0_push_latency: got %0d want 3 cycles", push_lat);
        end
        n_cmp++;
        if ({rx_valid, rx_data} !== {1'b1, 8'hA5}) begin
            n_bad++; $display("FAIL mode0_rx: got valid=%b data=%h want 1/a5", rx_valid, rx_data);
        end
        n_cmp++;
        if (mi !== 8'h3C) begin
            n_bad++; $display("FAIL mode0_miso: got %h want 3c", mi);
        end
        frame_end();
        drain_fifo();
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            n_bad++; $display("FAIL mode0_drain: got %0d bytes want 1 byte a5", got_q.size());
        end
    endtask

    task automatic test_mode3_back_to_back();
        logic [7:0] mi1, mi2;
        int und_base;
        und_base = und_pulses;
        set_mode(1'b1, 1'b1);
        frame_begin();
        spi_byte(8'h01, 8, 1'b0, mi1);
        spi_byte(8'h80, 8, 1'b0, mi2);
        frame_end();
        n_cmp++;
        if ({mi1, mi2} !== 16'hFFFF) begin
            n_bad++; $display("FAIL mode3_miso: got %h %h want ff ff", mi1, mi2);
        end
        n_cmp++;
        if (und_pulses - und_base !== 2) begin
            n_bad++; $display("FAIL mode3_underrun: got %0d pulses want 2", und_pulses - und_base);
        end
        n_cmp++;
        if (int'(rx_count) !== 2) begin
            n_bad++; $display("FAIL mode3_count: got %0d want 2", rx_count);
        end
        drain_fifo();
        n_cmp++;
        if (got_q.size() != 2 || got_q[0] !== 8'h01 || got_q[1] !== 8'h80) begin
            n_bad++; $display("FAIL mode3_order: got %0d bytes want 01,80", got_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] mi, b;
        int ovf_base, exp_ovf;
        ovf_base = ovf_pulses;
        exp_ovf  = 0;
        model_q.delete();
        set_mode(1'b0, 1'b0);
        frame_begin();
        for (int j = 0; j < DEPTH + 1; j++) begin
            b = 8'($urandom);
            spi_byte(b, 8, 1'b0, mi);
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovf++;
        end
        frame_end();
        n_cmp++;
        if (int'(rx_count) !== DEPTH) begin
            n_bad++; $display("FAIL ovf_count: got %0d want %0d", rx_count, DEPTH);
        end
        n_cmp++;
        if (ovf_pulses - ovf_base !== exp_ovf) begin
            n_bad++; $display("FAIL ovf_pulses: got %0d want %0d", ovf_pulses - ovf_base, exp_ovf);
        end
        drain_fifo();
        n_cmp++;
        if (got_q.size() != model_q.size()) begin
            n_bad++; $display("FAIL ovf_drain_size: got %0d want %0d", got_q.size(), model_q.size());
        end else begin
            foreach (model_q[i]) begin
                n_cmp++;
                if (got_q[i] !== model_q[i]) begin
                    n_bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, got_q[i], model_q[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] mi, b;
        int ovf_base;
        ovf_base = ovf_pulses;
        model_q.delete();
        set_mode(1'b0, 1'b1);
        frame_begin();
        for (int j = 0; j < DEPTH; j++) begin
            b = 8'($urandom);
            spi_byte(b, 8, 1'b0, mi);
            model_q.push_back(b);
        end
        b = 8'($urandom);
        spi_byte(b, 8, 1'b1, mi);
        void'(model_q.pop_front());
        model_q.push_back(b);
        frame_end();
        n_cmp++;
        if (ovf_pulses - ovf_base !== 0) begin
            n_bad++; $display("FAIL fullpop_overflow: got %0d pulses want 0", ovf_pulses - ovf_base);
        end
        n_cmp++;
        if (int'(rx_count) !== DEPTH) begin
            n_bad++; $display("FAIL fullpop_count: got %0d want %0d", rx_count, DEPTH);
        end
        drain_fifo();
        n_cmp++;
        if (got_q.size() != model_q.size()) begin
            n_bad++; $display("FAIL fullpop_drain_size: got %0d want %0d", got_q.size(), model_q.size());
        end else begin
            foreach (model_q[i]) begin
                n_cmp++;
                if (got_q[i] !== model_q[i]) begin
                    n_bad++; $display("FAIL fullpop_drain[%0d]: got %h want %h", i, got_q[i], model_q[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        set_mode(1'b1, 1'b0);
        frame_begin();
        spi_byte(8'($urandom), 5, 1'b0, mi);
        frame_end();
        n_cmp++;
        if (int'(rx_count) !== 0) begin
            n_bad++; $display("FAIL abort_partial: got count %0d want 0", rx_count);
        end
        frame_begin();
        spi_byte(8'h5A, 8, 1'b0, mi);
        frame_end();
        drain_fifo();
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
            n_bad++; $display("FAIL abort_next_byte: got %0d bytes want 1 byte 5a", got_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] mi, b, t;
        set_mode(1'b0, 1'b0);
        frame_begin();
        spi_byte(8'($urandom), 8, 1'b0, mi);
        spi_byte(8'($urandom), 8, 1'b0, mi);
        frame_end();
        n_cmp++;
        if (int'(rx_count) !== 2) begin
            n_bad++; $display("FAIL rstmid_queued: got %0d want 2", rx_count);
        end
        frame_begin();
        spi_byte(8'($urandom), 3, 1'b0, mi);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({spi_miso, rx_valid, overflow, underrun, frame_active, rx_data, rx_count} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_outputs: got miso=%b valid=%b ovf=%b und=%b fa=%b data=%h count=%0d want all 0",
                     spi_miso, rx_valid, overflow, underrun, frame_active, rx_data, rx_count);
        end
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        b = 8'($urandom);
        t = 8'($urandom);
        set_mode(1'b0, 1'b0);
        write_tx(t);
        frame_begin();
        spi_byte(b, 8, 1'b0, mi);
        frame_end();
        n_cmp++;
        if (mi !== t) begin
            n_bad++; $display("FAIL rstmid_miso: got %h want %h", mi, t);
        end
        drain_fifo();
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== b) begin
            n_bad++; $display("FAIL rstmid_rx: got %0d bytes want 1 byte %h", got_q.size(), b);
        end
    endtask

    task automatic test_random();
        logic [7:0] mi, b, t, exp_mi;
        int n, ovf_base;
        for (int f = 0; f < 12; f++) begin
            set_mode(1'($urandom), 1'($urandom));
            write_tx(8'($urandom));
            t = 8'($urandom);
            write_tx(t);
            n = $urandom_range(1, 3);
            ovf_base = ovf_pulses;
            model_q.delete();
            frame_begin();
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                spi_byte(b, 8, 1'b0, mi);
                model_q.push_back(b);
                exp_mi = (j == 0) ? t : 8'hFF;
                n_cmp++;
                if (mi !== exp_mi) begin
                    n_bad++; $display("FAIL rand_miso f%0d b%0d mode%0d%0d: got %h want %h",
                                      f, j, cpol, cpha, mi, exp_mi);
                end
            end
            frame_end();
            n_cmp++;
            if (ovf_pulses - ovf_base !== 0) begin
                n_bad++; $display("FAIL rand_overflow f%0d: got %0d pulses want 0", f, ovf_pulses - ovf_base);
            end
            drain_fifo();
            n_cmp++;
            if (got_q.size() != model_q.size()) begin
                n_bad++; $display("FAIL rand_size f%0d: got %0d want %0d", f, got_q.size(), model_q.size());
            end else begin
                foreach (model_q[i]) begin
                    n_cmp++;
                    if (got_q[i] !== model_q[i]) begin
                        n_bad++; $display("FAIL rand_rx f%0d[%0d]: got %h want %h", f, i, got_q[i], model_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        push_lat = -1;
        rst_n    = 1'b0;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        rx_ready = 1'b0;
        tx_data  = 8'h00;
        tx_wr    = 1'b0;

        test_reset();
        test_mode0();
        test_mode3_back_to_back();
        test_overflow();
        test_full_pop();
        test_abort();
        test_reset_mid_frame();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
